rob_retire: RTL and testbench
=============================

# rob_retire

Eight-entry reorder buffer for the Tomasulo core, handling allocation, CDB writeback capture and in-order retirement into the register bank. The dispatch stage writes entries in program order at the tail. Functional units broadcast results by tag on the common data bus (CDB). This block reads completed entries out at the head and drives one register-bank write per cycle.

## Interface
Parameters:
- DEPTH, 8, ROB entries; power of two.
- DATA_W, 16, result/register data width.
- REG_W, 4, architectural register index width (16 registers).

Ports:
- clk1  in  1  single system clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous and active-low.
- alloc_valid  in  1  dispatch requests one entry.
- alloc_dest  in  REG_W  destination register of the dispatched instruction.
- alloc_ready  out  1  entry available (count != DEPTH).
- alloc_tag  out  log2(DEPTH)  tag assigned to the current request (tail pointer).
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  log2(DEPTH)  ROB tag of the result.
- cdb_data  in  DATA_W  result value.
- commit_valid  out  1  registered one-cycle register-bank write strobe.
- commit_dest  out  REG_W  register written.
- commit_data  out  DATA_W  value written.
- commit_tag  out  log2(DEPTH)  tag retired.
- rob_empty  out  1  count == 0.
- rob_count  out  log2(DEPTH)+1  occupied entries.

## Operation
- Entry fields: busy, ready, dest, value. Head pointer, tail pointer and count are registers.
- Allocation fires on alloc_valid && alloc_ready:
  - entry[tail] gets busy=1, ready=0, dest=alloc_dest.
  - tail increments modulo DEPTH (7→0).
- CDB capture fires on cdb_valid:
  - If entry[cdb_tag].busy, set ready=1 and value=cdb_data.
  - If the entry is not busy, the broadcast is ignored silently.
- Retire fires when entry[head].busy && entry[head].ready:
  - commit_* are loaded from the entry.
  - busy is cleared and head increments modulo DEPTH.
  - Maximum one retire per cycle.
  - Otherwise commit_valid=0; commit_dest/data/tag hold their last values.
- Count update: +1 on allocate, −1 on retire, unchanged when both happen in the same cycle.
- alloc_ready, alloc_tag and rob_empty are combinational from registered count and tail.
- Boundary conditions:
  - Full: alloc_ready=0 even if a retire occurs in the same cycle; there is no bypass.
  - Empty: no retire occurs; head == tail.
  - CDB targeting head in cycle N: the entry retires at the next edge, not in cycle N.
  - CDB targeting the entry being allocated in the same cycle: the entry is not yet busy, so the CDB write is ignored and allocation wins.
  - Two broadcasts to the same tag: the last one wins until retire.
  - Reset asserted mid-operation: all in-flight entries are discarded.

## Timing
- Reset values (after a clock edge with rst_n=0):
  - All busy/ready = 0; head = tail = 0; rob_count = 0.
  - commit_valid = 0; commit_dest/data/tag = 0.
  - alloc_ready = 1; alloc_tag = 0; rob_empty = 1.
- Allocate at edge k: the entry is CDB-writable from edge k+1.
- CDB capture at edge k: commit_valid is high in the cycle after edge k+1, i.e. 2-edge writeback-to-commit latency.
- Back-to-back ready entries retire at one per cycle, with commit_valid held high continuously.

## Configuration
- ROB_FLUSH_EN defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge clears all busy/ready, sets head = tail = count = 0 and commit_valid = 0.
  - flush dominates allocate, CDB and retire in the same cycle.
- ROB_FLUSH_EN undefined: no flush port; entries leave only by retire or reset.

## Structure
- Shared package tomasulo_pkg holds:
  - ROB_DEPTH, TAG_W, REG_W, DATA_W constants.
  - rob_entry_t struct {busy, ready, dest, value}, reused by the reservation stations for tag compares.
- One sub-module, rob_ptr_ctr: a modulo-DEPTH pointer with an increment enable and synchronous clear. It is instantiated twice, for head and tail.

## Test plan
- Reset, then idle: rob_empty=1, alloc_ready=1, alloc_tag=0, commit_valid=0 throughout.
- Allocate dest 3 (tag 0); CDB tag 0 data 16'h00AA → two edges later commit_valid=1, commit_dest=3, commit_data=16'h00AA, commit_tag=0; rob_empty returns to 1.
- Out-of-order completion:
  - Stimulus: allocate dests 1, 2, 5 (tags 0, 1, 2); CDB tag 2=30, then tag 1=20, then tag 0=10.
  - Required: commits appear in order 1/10, 2/20, 5/30 on consecutive cycles.
- Fill and wrap-around:
  - Allocate 8 entries → rob_count=8, alloc_ready=0.
  - Alloc_valid held high while full → no allocation occurs.
  - Retire tag 0 → alloc_ready=1; next allocate receives tag 0.
- CDB to a non-busy tag 5 while only tags 0–1 are allocated → ignored; a later allocation of tag 5 starts with ready=0.
- With ROB_FLUSH_EN: allocate 4 entries, mark 2 ready, assert flush together with alloc_valid → rob_count=0, head=tail=0, no commit_valid pulse, and the next allocation receives tag 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: ROB sizing constants and the entry
// record that the reservation stations also use for tag compares.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int REG_W     = 4;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Modulo-DEPTH ROB pointer with increment enable and synchronous clear.
// DEPTH must be a power of two so the pointer wraps by natural overflow.
module rob_ptr_ctr #(
  parameter int DEPTH = tomasulo_pkg::ROB_DEPTH
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int TW = $clog2(DEPTH);

  logic [TW-1:0] ptr_q;
  logic [TW-1:0] ptr_d;

  // Next pointer: clear dominates, otherwise step by one and wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + TW'(1);
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: in-order allocation at the tail, CDB result capture by
// tag, and in-order retirement of one entry per cycle into the register
// bank. Optional feature macro: ROB_FLUSH_EN adds a 'flush' input that
// discards every in-flight entry.
module rob_retire #(
  parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int REG_W  = tomasulo_pkg::REG_W
) (
  input  logic                     clk1,
  input  logic                     rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_valid,
  input  logic [REG_W-1:0]         alloc_dest,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     cdb_valid,
  input  logic [$clog2(DEPTH)-1:0] cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  output logic                     commit_valid,
  output logic [REG_W-1:0]         commit_dest,
  output logic [DATA_W-1:0]        commit_data,
  output logic [$clog2(DEPTH)-1:0] commit_tag,
  output logic                     rob_empty,
  output logic [$clog2(DEPTH):0]   rob_count
);

  import tomasulo_pkg::*;

  localparam int TW = $clog2(DEPTH);
  localparam int CW = TW + 1;

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              commit_valid_q;
  logic              commit_valid_d;
  logic [REG_W-1:0]  commit_dest_q;
  logic [REG_W-1:0]  commit_dest_d;
  logic [DATA_W-1:0] commit_data_q;
  logic [DATA_W-1:0] commit_data_d;
  logic [TW-1:0]     commit_tag_q;
  logic [TW-1:0]     commit_tag_d;

  logic [TW-1:0]     head;
  logic [TW-1:0]     tail;
  logic              flush_w;
  logic              alloc_fire;
  logic              retire_fire;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // No bypass: a full ROB refuses allocation even while retiring.
  assign alloc_ready = (count_q != CW'(DEPTH));
  assign alloc_tag   = tail;
  assign rob_empty   = (count_q == '0);
  assign rob_count   = count_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign retire_fire = entries_q[head].busy && entries_q[head].ready;

  rob_ptr_ctr #(.DEPTH(DEPTH)) u_head (
    .clk1  (clk1),
    .rst_n (rst_n),
    .clr   (flush_w),
    .inc   (retire_fire),
    .ptr   (head)
  );

  rob_ptr_ctr #(.DEPTH(DEPTH)) u_tail (
    .clk1  (clk1),
    .rst_n (rst_n),
    .clr   (flush_w),
    .inc   (alloc_fire),
    .ptr   (tail)
  );

  // Entry updates: CDB capture only into busy entries, then retire clears
  // the head, then allocation claims the tail; flush wipes everything.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    if (cdb_valid && entries_q[cdb_tag].busy) begin
      entries_d[cdb_tag].ready = 1'b1;
      entries_d[cdb_tag].value = cdb_data;
    end
    if (retire_fire) begin
      entries_d[head].busy  = 1'b0;
      entries_d[head].ready = 1'b0;
    end
    if (alloc_fire) begin
      entries_d[tail].busy  = 1'b1;
      entries_d[tail].ready = 1'b0;
      entries_d[tail].dest  = alloc_dest;
    end
    if (flush_w) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].busy  = 1'b0;
        entries_d[i].ready = 1'b0;
      end
    end
  end

  // Occupancy and registered commit port; commit fields hold when idle.
  always_comb begin
    count_d        = count_q + CW'(alloc_fire) - CW'(retire_fire);
    commit_valid_d = retire_fire;
    commit_dest_d  = commit_dest_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;
    if (retire_fire) begin
      commit_dest_d = entries_q[head].dest;
      commit_data_d = entries_q[head].value;
      commit_tag_d  = head;
    end
    if (flush_w) begin
      count_d        = '0;
      commit_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: reset state, single and out-of-order
// completion, fill/wrap with simultaneous allocate+retire, CDB to idle
// tags, last-write-wins, mid-run reset and (with ROB_FLUSH_EN) flush.
module tb_rob_retire;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_dest;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic        rob_empty;
  logic [3:0]  rob_count;

  int n_cmp = 0;
  int n_err = 0;

  rob_retire #(.DEPTH(8), .DATA_W(16), .REG_W(4)) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
`ifdef ROB_FLUSH_EN
    .flush        (flush),
`endif
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag),
    .rob_empty    (rob_empty),
    .rob_count    (rob_count)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;

    // Reset state and idle
    do_reset();
    chk("rst_empty", rob_empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_count", rob_count, 0);
    chk("rst_cdest", commit_dest, 0);
    chk("rst_cdata", commit_data, 0);
    chk("rst_ctag", commit_tag, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_cvalid", commit_valid, 0);
      chk("idle_empty", rob_empty, 1);
      chk("idle_tag", alloc_tag, 0);
    end

    // Single instruction: allocate dest 3, writeback AA, commit two edges later
    alloc_valid = 1'b1; alloc_dest = 4'd3;
    tick();
    alloc_valid = 1'b0;
    chk("one_count", rob_count, 1);
    chk("one_empty", rob_empty, 0);
    chk("one_tag", alloc_tag, 1);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h00AA;
    tick();
    cdb_valid = 1'b0;
    chk("one_early", commit_valid, 0);
    tick();
    chk("one_cvalid", commit_valid, 1);
    chk("one_cdest", commit_dest, 3);
    chk("one_cdata", commit_data, 16'h00AA);
    chk("one_ctag", commit_tag, 0);
    chk("one_empty2", rob_empty, 1);
    tick();
    chk("one_drop", commit_valid, 0);
    chk("one_hold", commit_data, 16'h00AA);

    // Out-of-order completion, in-order commit
    do_reset();
    alloc_valid = 1'b1;
    alloc_dest = 4'd1; chk("ooo_t0", alloc_tag, 0); tick();
    alloc_dest = 4'd2; chk("ooo_t1", alloc_tag, 1); tick();
    alloc_dest = 4'd5; chk("ooo_t2", alloc_tag, 2); tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag = 3'd2; cdb_data = 16'd30; tick();
    chk("ooo_wait1", commit_valid, 0);
    cdb_tag = 3'd1; cdb_data = 16'd20; tick();
    chk("ooo_wait2", commit_valid, 0);
    cdb_tag = 3'd0; cdb_data = 16'd10; tick();
    cdb_valid = 1'b0;
    chk("ooo_wait3", commit_valid, 0);
    tick();
    chk("ooo_c0v", commit_valid, 1);
    chk("ooo_c0", {commit_dest, commit_data}, {4'd1, 16'd10});
    tick();
    chk("ooo_c1v", commit_valid, 1);
    chk("ooo_c1", {commit_dest, commit_data}, {4'd2, 16'd20});
    tick();
    chk("ooo_c2v", commit_valid, 1);
    chk("ooo_c2", {commit_dest, commit_data}, {4'd5, 16'd30});
    chk("ooo_c2tag", commit_tag, 2);
    tick();
    chk("ooo_end", commit_valid, 0);
    chk("ooo_empty", rob_empty, 1);

    // Reset mid-operation discards in-flight entries
    alloc_valid = 1'b1; alloc_dest = 4'd7;
    tick(); tick();
    alloc_valid = 1'b0;
    chk("mid_pre", rob_count, 2);
    do_reset();
    chk("mid_count", rob_count, 0);
    chk("mid_tag", alloc_tag, 0);
    chk("mid_empty", rob_empty, 1);

    // Fill to full, hold alloc_valid, last-wins, retire with wrap
    alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_dest = 4'(i);
      tick();
    end
    chk("full_count", rob_count, 8);
    chk("full_ready", alloc_ready, 0);
    chk("full_tag", alloc_tag, 0);
    tick();
    chk("full_hold", rob_count, 8);
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0055; tick();
    cdb_tag = 3'd1; cdb_data = 16'h0066; tick();
    chk("full_noret", commit_valid, 0);
    cdb_tag = 3'd0; cdb_data = 16'h0011; tick();
    cdb_valid = 1'b0;
    chk("full_ready2", alloc_ready, 0);
    chk("full_count2", rob_count, 8);
    alloc_dest = 4'd9;
    tick();
    chk("wrap_c0v", commit_valid, 1);
    chk("wrap_c0", {commit_tag, commit_data}, {3'd0, 16'h0011});
    chk("wrap_count", rob_count, 7);
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    chk("both_cv", commit_valid, 1);
    chk("both_last", {commit_dest, commit_data}, {4'd1, 16'h0066});
    chk("both_count", rob_count, 7);
    chk("both_tag", alloc_tag, 1);

    // CDB to a non-busy tag is ignored
    do_reset();
    alloc_valid = 1'b1;
    alloc_dest = 4'd4; tick();
    alloc_dest = 4'd6; tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0077; tick();
    cdb_valid = 1'b0;
    alloc_valid = 1'b1;
    alloc_dest = 4'd8; tick();
    tick();
    tick();
    alloc_dest = 4'd7; chk("nb_tag5", alloc_tag, 5); tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cdb_tag = 3'(i); cdb_data = 16'(16'h0100 + i);
      tick();
    end
    cdb_valid = 1'b0;
    tick();
    chk("nb_c4v", commit_valid, 1);
    chk("nb_c4", {commit_tag, commit_data}, {3'd4, 16'h0104});
    tick();
    chk("nb_stall", commit_valid, 0);
    chk("nb_count", rob_count, 1);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0099; tick();
    cdb_valid = 1'b0;
    chk("nb_wait", commit_valid, 0);
    tick();
    chk("nb_c5v", commit_valid, 1);
    chk("nb_c5", {commit_tag, commit_dest, commit_data}, {3'd5, 4'd7, 16'h0099});
    chk("nb_empty", rob_empty, 1);

`ifdef ROB_FLUSH_EN
    // Flush dominates allocate and discards ready entries
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_dest = 4'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag = 3'd1; cdb_data = 16'h0A01; tick();
    cdb_tag = 3'd2; cdb_data = 16'h0A02; tick();
    cdb_valid = 1'b0;
    flush = 1'b1; alloc_valid = 1'b1;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    chk("fl_count", rob_count, 0);
    chk("fl_tag", alloc_tag, 0);
    chk("fl_empty", rob_empty, 1);
    chk("fl_cv", commit_valid, 0);
    tick();
    chk("fl_cv2", commit_valid, 0);
    alloc_valid = 1'b1; alloc_dest = 4'd2;
    chk("fl_next", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    chk("fl_after", alloc_tag, 1);
    chk("fl_count2", rob_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
